// File: rtl/npc_pkg.sv
// npc_pkg: shared register-file constants and types for the writeback path.
//   REG_ADDR_W - width of a register index (32 architectural registers)
//   XLEN       - natural data width of a register
//   REG_ZERO   - index of the hard-wired zero register x0
//   wb_req_t   - one writeback request: destination register plus data
package npc_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 64;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: tracks destination registers of loads still in flight.
//   clk, rst_n          - clock, asynchronous active-low reset
//   iss_valid/iss_ready - load issue handshake, iss_rd its destination
//   l_valid, l_rd       - load response (always consumed)
//   raddr1, raddr2      - decode read addresses
//   rs1_busy, rs2_busy  - read address has a load outstanding (current state)
//   err                 - sticky: response with nothing outstanding for it
module wb_scoreboard
    import npc_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic                  l_valid,
    input  logic [REG_ADDR_W-1:0] l_rd,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  err
);

    // Four bits cover the full 1..15 range of MAX_OUT.
    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [31:0]      busy, busy_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             same_rd, iss_set, l_clr, cnt_dec, l_bad;

    // A response retiring the same register frees the slot in the same
    // cycle, so a back-to-back reload of that register need not stall.
    assign same_rd   = l_valid & (l_rd == iss_rd);
    assign iss_ready = (cnt < CNT_MAX) & (~busy[iss_rd] | same_rd);

    // x0 loads are never tracked, so neither are their responses.
    assign iss_set = iss_valid & iss_ready & (iss_rd != REG_ZERO);
    assign l_clr   = l_valid & (l_rd != REG_ZERO);
    assign cnt_dec = l_clr & (cnt != '0);
    assign l_bad   = l_valid & ((l_clr & ~busy[l_rd]) | (cnt == '0));

    assign rs1_busy = busy[raddr1] & (raddr1 != REG_ZERO);
    assign rs2_busy = busy[raddr2] & (raddr2 != REG_ZERO);

    always_comb begin
        busy_nxt = busy;
        // Clear first so a same-register set in the same cycle wins.
        if (l_clr)   busy_nxt[l_rd]   = 1'b0;
        if (iss_set) busy_nxt[iss_rd] = 1'b1;
        // iss_ready already bounds the increment; the decrement saturates.
        cnt_nxt = cnt + {{(CNT_W-1){1'b0}}, iss_set} - {{(CNT_W-1){1'b0}}, cnt_dec};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            cnt  <= cnt_nxt;
            if (l_bad) err <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and LSU results onto the single register-file write
// port, tracks outstanding loads and forwards the write in flight.
//   clk, rst_n                - clock, asynchronous active-low reset
//   a_valid/a_ready/a_rd/a_data - ALU result source
//   iss_valid/iss_ready/iss_rd  - load issue to the LSU
//   l_valid/l_rd/l_data         - LSU response, no backpressure
//   waddr/wdata/wen             - register-file write port (registered)
//   raddr1/raddr2               - decode read addresses
//   rs1_busy/rs2_busy           - read address waits on an outstanding load
//   fwd1_hit/fwd2_hit/fwd_data  - read address matches the write on the port
//   err                         - sticky protocol error
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload stable until that edge;
// ready may depend combinationally on the same cycle's inputs. l_valid has
// no ready and is consumed on every edge where it is high.
module wb_arbiter
    import npc_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic                  l_valid,
    input  logic [REG_ADDR_W-1:0] l_rd,
    input  logic [DATA_WIDTH-1:0] l_data,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wen,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  err
);

    logic a_acc;

    // The LSU cannot be stalled, so it always owns the port when valid.
    assign a_ready = ~l_valid;
    assign a_acc   = a_valid & a_ready;

    // Results to x0 are consumed but never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen   <= 1'b0;
            waddr <= REG_ZERO;
            wdata <= '0;
        end else if (l_valid) begin
            wen   <= (l_rd != REG_ZERO);
            waddr <= l_rd;
            wdata <= l_data;
        end else if (a_acc) begin
            wen   <= (a_rd != REG_ZERO);
            waddr <= a_rd;
            wdata <= a_data;
        end else begin
            wen   <= 1'b0;
        end
    end

    // The register file commits on the next edge; decode reads this instead.
    assign fwd1_hit = wen & (waddr != REG_ZERO) & (waddr == raddr1);
    assign fwd2_hit = wen & (waddr != REG_ZERO) & (waddr == raddr2);
    assign fwd_data = wdata;

    wb_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .l_valid   (l_valid),
        .l_rd      (l_rd),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .err       (err)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int DW      = 64;
    localparam int MAX_OUT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_valid, a_ready, iss_valid, iss_ready, l_valid, wen;
    logic [4:0]    a_rd, iss_rd, l_rd, waddr, raddr1, raddr2;
    logic [DW-1:0] a_data, l_data, wdata, fwd_data;
    logic          rs1_busy, rs2_busy, fwd1_hit, fwd2_hit, err;

    wb_arbiter #(.DATA_WIDTH(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data),
        .waddr(waddr), .wdata(wdata), .wen(wen),
        .raddr1(raddr1), .raddr2(raddr2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
        .err(err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        a_valid = 0; a_rd = 0; a_data = '0;
        iss_valid = 0; iss_rd = 0;
        l_valid = 0; l_rd = 0; l_data = '0;
        raddr1 = 0; raddr2 = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic av; logic [4:0] ard; logic [63:0] adata;
        logic iv; logic [4:0] ird;
        logic lv; logic [4:0] lrd; logic [63:0] ldata;
        logic [4:0] r1, r2;
        logic e_ar, e_ir, e_wen, chk_w;
        logic [4:0] e_waddr; logic [63:0] e_wdata;
        logic e_b1, e_b2, e_f1, e_f2, e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;

    function automatic void vin(int av, int ard, int adata, int iv, int ird,
                                int lv, int lrd, int ldata, int r1, int r2);
        cur.av = (av != 0); cur.ard = 5'(ard); cur.adata = 64'(adata);
        cur.iv = (iv != 0); cur.ird = 5'(ird);
        cur.lv = (lv != 0); cur.lrd = 5'(lrd); cur.ldata = 64'(ldata);
        cur.r1 = 5'(r1); cur.r2 = 5'(r2);
    endfunction

    // chk_w: compare waddr/wdata (also used to check they hold while wen=0)
    function automatic void vexp(int ar, int ir, int w, int chkw, int wa, int wd,
                                 int b1, int b2, int f1, int f2, int e);
        cur.e_ar = (ar != 0); cur.e_ir = (ir != 0); cur.e_wen = (w != 0);
        cur.chk_w = (chkw != 0); cur.e_waddr = 5'(wa); cur.e_wdata = 64'(wd);
        cur.e_b1 = (b1 != 0); cur.e_b2 = (b2 != 0);
        cur.e_f1 = (f1 != 0); cur.e_f2 = (f2 != 0); cur.e_err = (e != 0);
        vecs.push_back(cur);
    endfunction

    task automatic apply_vec(input vec_t v);
        a_valid = v.av; a_rd = v.ard; a_data = v.adata;
        iss_valid = v.iv; iss_rd = v.ird;
        l_valid = v.lv; l_rd = v.lrd; l_data = v.ldata;
        raddr1 = v.r1; raddr2 = v.r2;
    endtask

    // ---------------- reference model for random phase ----------------
    logic [4:0]  out_q[$];      // destinations of loads in flight
    logic [69:0] exp_q[$];      // {wen, waddr, wdata} expected next cycle

    function automatic logic in_flight(logic [4:0] r);
        if (r == 0) return 1'b0;
        foreach (out_q[i]) if (out_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void retire(logic [4:0] r);
        for (int i = 0; i < out_q.size(); i++)
            if (out_q[i] == r) begin
                out_q.delete(i);
                return;
            end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        // table: each row = inputs for one cycle, outputs observed that cycle
        vin(1,5,'h1234,0,0,0,0,0,5,0);  vexp(1,1,0,0,0,0,      0,0,0,0,0);
        vin(0,0,0,0,0,0,0,0,5,0);       vexp(1,1,1,1,5,'h1234, 0,0,1,0,0);
        vin(0,0,0,1,7,0,0,0,7,0);       vexp(1,1,0,1,5,'h1234, 0,0,0,0,0);
        vin(1,3,'h33,0,0,1,7,'h77,7,0); vexp(0,1,0,1,5,'h1234, 1,0,0,0,0);
        vin(1,3,'h33,0,0,0,0,0,7,0);    vexp(1,1,1,1,7,'h77,   0,0,1,0,0);
        vin(0,0,0,0,0,0,0,0,3,0);       vexp(1,1,1,1,3,'h33,   0,0,1,0,0);
        vin(0,0,0,0,0,0,0,0,3,0);       vexp(1,1,0,1,3,'h33,   0,0,0,0,0);
        vin(0,0,0,1,9,0,0,0,9,0);       vexp(1,1,0,1,3,'h33,   0,0,0,0,0);
        vin(0,0,0,1,9,0,0,0,9,0);       vexp(1,0,0,0,0,0,      1,0,0,0,0);
        vin(0,0,0,0,9,1,9,'h99,9,0);    vexp(0,1,0,0,0,0,      1,0,0,0,0);
        vin(0,0,0,0,0,0,0,0,9,0);       vexp(1,1,1,1,9,'h99,   0,0,1,0,0);
        vin(0,0,0,1,9,0,0,0,9,0);       vexp(1,1,0,0,0,0,      0,0,0,0,0);
        vin(0,0,0,1,9,1,9,'hAA,9,0);    vexp(0,1,0,0,0,0,      1,0,0,0,0);
        vin(0,0,0,0,0,0,0,0,9,0);       vexp(1,1,1,1,9,'hAA,   1,0,1,0,0);
        vin(0,0,0,1,1,0,0,0,9,0);       vexp(1,1,0,0,0,0,      1,0,0,0,0);
        vin(0,0,0,1,2,0,0,0,9,0);       vexp(1,1,0,0,0,0,      1,0,0,0,0);
        vin(0,0,0,1,3,0,0,0,9,0);       vexp(1,1,0,0,0,0,      1,0,0,0,0);
        vin(0,0,0,1,4,0,0,0,9,3);       vexp(1,0,0,0,0,0,      1,1,0,0,0);
        vin(0,0,0,0,4,1,1,'h11,9,3);    vexp(0,0,0,0,0,0,      1,1,0,0,0);
        vin(0,0,0,1,4,0,0,0,9,1);       vexp(1,1,1,1,1,'h11,   1,0,0,1,0);
        vin(0,0,0,0,0,0,0,0,4,1);       vexp(1,0,0,0,0,0,      1,0,0,0,0);
        vin(0,0,0,0,0,1,9,'h9A,9,4);    vexp(0,0,0,0,0,0,      1,1,0,0,0);
        vin(0,0,0,0,0,1,2,'h22,9,4);    vexp(0,1,1,1,9,'h9A,   0,1,1,0,0);
        vin(0,0,0,0,0,1,3,'h23,2,4);    vexp(0,1,1,1,2,'h22,   0,1,1,0,0);
        vin(0,0,0,0,0,1,4,'h24,3,4);    vexp(0,1,1,1,3,'h23,   0,1,1,0,0);
        vin(1,0,'hFF,0,0,0,0,0,0,4);    vexp(1,1,1,1,4,'h24,   0,0,0,1,0);
        vin(0,0,0,1,0,0,0,0,0,0);       vexp(1,1,0,0,0,0,      0,0,0,0,0);
        vin(0,0,0,1,1,0,0,0,0,0);       vexp(1,1,0,0,0,0,      0,0,0,0,0);
        vin(0,0,0,1,2,0,0,0,0,0);       vexp(1,1,0,0,0,0,      0,0,0,0,0);
        vin(0,0,0,1,3,0,0,0,0,0);       vexp(1,1,0,0,0,0,      0,0,0,0,0);
        vin(0,0,0,1,4,0,0,0,4,0);       vexp(1,1,0,0,0,0,      0,0,0,0,0);
        vin(0,0,0,0,0,1,1,'h41,4,0);    vexp(0,0,0,0,0,0,      1,0,0,0,0);
        vin(0,0,0,0,0,1,2,'h42,4,0);    vexp(0,1,1,1,1,'h41,   1,0,0,0,0);
        vin(0,0,0,0,0,1,3,'h43,4,0);    vexp(0,1,1,1,2,'h42,   1,0,0,0,0);
        vin(0,0,0,0,0,1,4,'h44,4,0);    vexp(0,1,1,1,3,'h43,   1,0,0,0,0);
        vin(0,0,0,0,0,1,12,'hC0,12,0);  vexp(0,1,1,1,4,'h44,   0,0,0,0,0);
        vin(0,0,0,0,0,0,0,0,12,0);      vexp(1,1,1,1,12,'hC0,  0,0,1,0,1);

        // reset state, sampled while reset is still asserted
        #2;
        chk("rst_wen", 64'(wen), 0);
        chk("rst_waddr", 64'(waddr), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_err", 64'(err), 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            apply_vec(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_a_ready", i), 64'(a_ready), 64'(vecs[i].e_ar));
            chk($sformatf("v%0d_iss_ready", i), 64'(iss_ready), 64'(vecs[i].e_ir));
            chk($sformatf("v%0d_wen", i), 64'(wen), 64'(vecs[i].e_wen));
            if (vecs[i].chk_w) begin
                chk($sformatf("v%0d_waddr", i), 64'(waddr), 64'(vecs[i].e_waddr));
                chk($sformatf("v%0d_wdata", i), wdata, vecs[i].e_wdata);
                chk($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_wdata);
            end
            chk($sformatf("v%0d_rs1_busy", i), 64'(rs1_busy), 64'(vecs[i].e_b1));
            chk($sformatf("v%0d_rs2_busy", i), 64'(rs2_busy), 64'(vecs[i].e_b2));
            chk($sformatf("v%0d_fwd1_hit", i), 64'(fwd1_hit), 64'(vecs[i].e_f1));
            chk($sformatf("v%0d_fwd2_hit", i), 64'(fwd2_hit), 64'(vecs[i].e_f2));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].e_err));
        end

        // mid-cycle reset clears err, write port and busy without an edge
        @(posedge clk); #1;
        drive_idle();
        iss_valid = 1; iss_rd = 5; a_valid = 1; a_rd = 6; a_data = 64'h66; raddr1 = 5;
        @(posedge clk); #1;
        drive_idle();
        raddr1 = 5;
        #1;
        chk("pre_rst_err", 64'(err), 1);
        chk("pre_rst_busy", 64'(rs1_busy), 1);
        chk("pre_rst_wen", 64'(wen), 1);
        chk("pre_rst_waddr", 64'(waddr), 6);
        rst_n = 0;
        #1;
        chk("async_rst_err", 64'(err), 0);
        chk("async_rst_wen", 64'(wen), 0);
        chk("async_rst_waddr", 64'(waddr), 0);
        chk("async_rst_wdata", wdata, 0);
        chk("async_rst_busy", 64'(rs1_busy), 0);
        @(negedge clk);
        rst_n = 1;
        // a response for a load lost to reset is an error but still written
        @(posedge clk); #1;
        l_valid = 1; l_rd = 5; l_data = 64'h55;
        @(negedge clk);
        chk("late_rsp_err_before", 64'(err), 0);
        @(posedge clk); #1;
        drive_idle();
        raddr1 = 5;
        @(negedge clk);
        chk("late_rsp_err", 64'(err), 1);
        chk("late_rsp_wen", 64'(wen), 1);
        chk("late_rsp_waddr", 64'(waddr), 5);
        chk("late_rsp_wdata", wdata, 64'h55);
        chk("late_rsp_fwd1", 64'(fwd1_hit), 1);

        // randomized phase against the model
        do_reset();
        out_q.delete();
        exp_q.delete();
        exp_q.push_back(70'b0);
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic        a_keep, e_ir, e_wen;
            logic [4:0]  e_addr;
            logic [63:0] e_data;
            logic [69:0] e;
            @(posedge clk); #1;
            a_keep = a_valid & l_valid;   // ALU result still waiting
            if (!a_keep) begin
                a_valid = 1'($urandom_range(0, 1));
                a_rd    = 5'($urandom_range(0, 31));
                a_data  = {$urandom, $urandom};
            end
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_rd    = 5'($urandom_range(0, 7));
            if (out_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                l_valid = 1;
                l_rd    = out_q[$urandom_range(0, out_q.size() - 1)];
            end else begin
                l_valid = 0;
                l_rd    = 5'($urandom_range(0, 31));
            end
            l_data = {$urandom, $urandom};
            raddr1 = 5'($urandom_range(0, 7));
            raddr2 = 5'($urandom_range(0, 7));
            @(negedge clk);

            e = exp_q.pop_front();
            e_wen = e[69]; e_addr = e[68:64]; e_data = e[63:0];
            chk("rnd_wen", 64'(wen), 64'(e_wen));
            if (e_wen) begin
                chk("rnd_waddr", 64'(waddr), 64'(e_addr));
                chk("rnd_wdata", wdata, e_data);
                chk("rnd_fwd_data", fwd_data, e_data);
            end
            chk("rnd_fwd1", 64'(fwd1_hit), 64'(e_wen && e_addr == raddr1));
            chk("rnd_fwd2", 64'(fwd2_hit), 64'(e_wen && e_addr == raddr2));
            chk("rnd_a_ready", 64'(a_ready), 64'(!l_valid));
            e_ir = (out_q.size() < MAX_OUT) &&
                   (!in_flight(iss_rd) || (l_valid && l_rd == iss_rd));
            chk("rnd_iss_ready", 64'(iss_ready), 64'(e_ir));
            chk("rnd_rs1_busy", 64'(rs1_busy), 64'(in_flight(raddr1)));
            chk("rnd_rs2_busy", 64'(rs2_busy), 64'(in_flight(raddr2)));
            chk("rnd_err", 64'(err), 0);

            if (l_valid) retire(l_rd);
            if (iss_valid && e_ir && iss_rd != 0) out_q.push_back(iss_rd);
            if (l_valid)
                exp_q.push_back({l_rd != 0, l_rd, l_data});
            else if (a_valid)
                exp_q.push_back({a_rd != 0, a_rd, a_data});
            else
                exp_q.push_back({1'b0, e_addr, e_data});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
